// File: rtl/id_ex_stage_pkg.sv
// ID/EX shared types: ALU op classes, control bundle, register address constants.
// Imported by id_ex_stage and hazard_detect.
package id_ex_stage_pkg;

  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_FUNC = 3'b010,
    ALU_OR   = 3'b011,
    ALU_AND  = 3'b100,
    ALU_SLT  = 3'b101
  } alu_op_e;

  // Field order is fixed; a bubble is simply '0.
  typedef struct packed {
    logic    reg_write;
    logic    mem_to_reg;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    alu_src;
    logic    reg_dst;
    alu_op_e alu_op;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detect: stall when a valid load in EX writes a source of ID.
// Ports: ex_mem_read/ex_valid/ex_rt from ID/EX, id_rs/id_rt from IF/ID; stall out.
module hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic              ex_mem_read,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic              stall
);

  logic hit;

  assign hit   = (ex_rt == id_rs) | (ex_rt == id_rt);
  assign stall = ex_mem_read & ex_valid
               & (ex_rt != REG_ZERO) & hit;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and flush bubble insertion.
// Ports: clk_i, rst_i, flush_i, IF/ID sources, decoded fields in; ID_EX_* out, Stall_o.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic [4:0]        IF_ID_RS_addr_i,
  input  logic [4:0]        IF_ID_RT_addr_i,
  input  logic [DATA_W-1:0] RS_data_i,
  input  logic [DATA_W-1:0] RT_data_i,
  input  logic [DATA_W-1:0] Imm_i,
  input  logic [4:0]        RS_addr_i,
  input  logic [4:0]        RT_addr_i,
  input  logic [4:0]        RD_addr_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              Branch_i,
  input  logic              ALUSrc_i,
  input  logic              RegDst_i,
  input  logic [2:0]        ALUOp_i,
  output logic [DATA_W-1:0] ID_EX_RS_data_o,
  output logic [DATA_W-1:0] ID_EX_RT_data_o,
  output logic [DATA_W-1:0] ID_EX_Imm_o,
  output logic [4:0]        ID_EX_RS_addr_o,
  output logic [4:0]        ID_EX_RT_addr_o,
  output logic [4:0]        ID_EX_RD_addr_o,
  output logic              ID_EX_RegWrite_o,
  output logic              ID_EX_MemtoReg_o,
  output logic              ID_EX_MemRead_o,
  output logic              ID_EX_MemWrite_o,
  output logic              ID_EX_Branch_o,
  output logic              ID_EX_ALUSrc_o,
  output logic              ID_EX_RegDst_o,
  output logic [2:0]        ID_EX_ALUOp_o,
  output logic              ID_EX_Valid_o,
  output logic              Stall_o
);

  ctrl_t             ctrl_d;
  ctrl_t             ctrl_q;
  logic              valid_q;
  logic [4:0]        rs_q;
  logic [4:0]        rt_q;
  logic [4:0]        rd_q;
  logic [DATA_W-1:0] rs_data_q;
  logic [DATA_W-1:0] rt_data_q;
  logic [DATA_W-1:0] imm_q;
  logic              bubble;

  always_comb begin
    ctrl_d            = '0;
    ctrl_d.reg_write  = RegWrite_i;
    ctrl_d.mem_to_reg = MemtoReg_i;
    ctrl_d.mem_read   = MemRead_i;
    ctrl_d.mem_write  = MemWrite_i;
    ctrl_d.branch     = Branch_i;
    ctrl_d.alu_src    = ALUSrc_i;
    ctrl_d.reg_dst    = RegDst_i;
    ctrl_d.alu_op     = alu_op_e'(ALUOp_i);
  end

  hazard_detect u_hazard (
    .ex_mem_read (ctrl_q.mem_read),
    .ex_valid    (valid_q),
    .ex_rt       (rt_q),
    .id_rs       (IF_ID_RS_addr_i),
    .id_rt       (IF_ID_RT_addr_i),
    .stall       (Stall_o)
  );

  // Flush wins over stall, but both produce the same all-zero bubble.
  assign bubble = flush_i | Stall_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q    <= '0;
      valid_q   <= 1'b0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
    end else if (bubble) begin
      ctrl_q    <= '0;
      valid_q   <= 1'b0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      valid_q   <= 1'b1;
      rs_q      <= RS_addr_i;
      rt_q      <= RT_addr_i;
      rd_q      <= RD_addr_i;
      rs_data_q <= RS_data_i;
      rt_data_q <= RT_data_i;
      imm_q     <= Imm_i;
    end
  end

  assign ID_EX_RS_data_o  = rs_data_q;
  assign ID_EX_RT_data_o  = rt_data_q;
  assign ID_EX_Imm_o      = imm_q;
  assign ID_EX_RS_addr_o  = rs_q;
  assign ID_EX_RT_addr_o  = rt_q;
  assign ID_EX_RD_addr_o  = rd_q;
  assign ID_EX_RegWrite_o = ctrl_q.reg_write;
  assign ID_EX_MemtoReg_o = ctrl_q.mem_to_reg;
  assign ID_EX_MemRead_o  = ctrl_q.mem_read;
  assign ID_EX_MemWrite_o = ctrl_q.mem_write;
  assign ID_EX_Branch_o   = ctrl_q.branch;
  assign ID_EX_ALUSrc_o   = ctrl_q.alu_src;
  assign ID_EX_RegDst_o   = ctrl_q.reg_dst;
  assign ID_EX_ALUOp_o    = ctrl_q.alu_op;
  assign ID_EX_Valid_o    = valid_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the datapath width of register operands and immediate.
REQ-002 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  SHALL be the reset, asynchronous and active-high.
REQ-004 flush_i  input  1  SHALL request that the next capture be a bubble (taken branch/jump).
REQ-005 IF_ID_RS_addr_i, IF_ID_RT_addr_i  input  5 each  SHALL be the source fields of the instruction currently in decode.
REQ-006 RS_data_i, RT_data_i, Imm_i  input  DATA_W each  SHALL be the register-file reads and the sign-extended immediate.
REQ-007 RS_addr_i, RT_addr_i, RD_addr_i  input  5 each  SHALL be the decoded register addresses.
REQ-008 RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, Branch_i, ALUSrc_i, RegDst_i  input  1 each  SHALL be the decoded control bits.
REQ-009 ALUOp_i  input  3  SHALL be the decoded ALU operation class.
REQ-010 Every input in REQ-006..REQ-009 SHALL have a registered output of the same width named with prefix ID_EX_ and suffix _o (e.g. ID_EX_RS_addr_o).
REQ-011 ID_EX_Valid_o  output  1  SHALL be high when the EX-stage slot holds a real instruction.
REQ-012 Stall_o  output  1  SHALL tell the PC and IF/ID register to hold (load-use hazard).

Function
REQ-013 Stall_o SHALL be combinational: ID_EX_MemRead_o & ID_EX_Valid_o & (ID_EX_RT_addr_o != 0) & ((ID_EX_RT_addr_o == IF_ID_RS_addr_i) | (ID_EX_RT_addr_o == IF_ID_RT_addr_i)).
REQ-014 Per rising edge, the register SHALL capture in priority order: flush_i=1 -> bubble; else Stall_o=1 -> bubble; else all inputs with Valid=1.
REQ-015 Bubble: all control outputs (REQ-008, REQ-009) and ID_EX_Valid_o SHALL be 0; address fields SHALL be 0 so downstream forwarding never matches; data fields SHALL be 0.
REQ-016 Latency SHALL be exactly one cycle from input to ID_EX_ output; no combinational path from any _i to any ID_EX_ output.
REQ-017 Stall SHALL last exactly one cycle per load-use pair: the bubble clears ID_EX_MemRead_o, dropping Stall_o next cycle.
REQ-018 Back-to-back loads, each feeding the next, SHALL each produce one stall cycle.
REQ-019 flush_i and Stall_o together SHALL yield one bubble; Stall_o still asserts that cycle (upstream holds; flush overrides upstream).
REQ-020 A load whose RT is $0 SHALL never stall.
REQ-021 Address fields SHALL pass unmodified (RegDst selection is done in EX, not here).

Reset
REQ-022 While rst_i=1, every ID_EX_ output and ID_EX_Valid_o SHALL be 0 immediately, independent of clk_i; Stall_o therefore 0.
REQ-023 Reset asserted mid-stall SHALL clear the stall; first edge after release SHALL capture normally per REQ-014.

Structure
REQ-024 Shared package SHALL hold: ALUOp encodings (3-bit), control-bundle field order, register-address width (5), $0 address constant.
REQ-025 Hazard detection (REQ-013) SHALL be a sub-module named hazard_detect; the pipeline register stays in id_ex_stage.
REQ-026 Control bits SHALL be registered as one bundle so bubble insertion is a single mux select.

Verification
REQ-027 Reset: rst_i=1 async between edges -> all outputs 0 within same cycle; Stall_o=0.
REQ-028 Pass-through: RS_data_i=0x0000_1234, RT_addr_i=9, RegWrite_i=1, ALUOp_i=3'b010 -> next edge ID_EX_ outputs equal, Valid=1.
REQ-029 Load-use: lw RT=8 in EX, IF_ID_RS_addr_i=8 -> Stall_o=1 one cycle, next edge bubble (Valid=0, MemRead=0), following cycle Stall_o=0.
REQ-030 $0 case: lw RT=0 in EX, IF_ID_RT_addr_i=0 -> Stall_o=0, normal capture.
REQ-031 Flush: flush_i=1 with RegWrite_i=1, MemWrite_i=1 -> next edge all controls 0, Valid=0, addresses 0.
REQ-032 Flush+stall same cycle -> exactly one bubble, then normal capture of held instruction on following edge.
